// File: rtl/acdma_crossbar_top_pkg.sv
// Shared constants and the Walsh code helper for the aggregated-CDMA crossbar.
package AggrCDMAPkg;

    localparam int NUM_PORTS     = 4;
    localparam int DATA_WIDTH    = 32;
    localparam int COUNTER_WIDTH = $clog2(NUM_PORTS);
    localparam int CHIP_WIDTH    = DATA_WIDTH + COUNTER_WIDTH + 1;
    localparam int ACC_WIDTH     = DATA_WIDTH + 2 * COUNTER_WIDTH + 1;

    // Returns 1 when W_i[c] is -1 (odd parity of i & c), 0 when it is +1.
    function automatic logic walsh_sign(input int unsigned i, input int unsigned c);
        return ^(i & c);
    endfunction

endpackage

// File: rtl/acdma_despreader.sv
// Single-port Walsh despreader: accumulates one code period of chips and
// registers the recovered word. Define ACDMA_ASSERT_EN for simulation checks.
module acdma_despreader
    import AggrCDMAPkg::*;
#(
    parameter int unsigned PORT_IDX = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [CHIP_WIDTH-1:0] i_chip,
    input  logic [COUNTER_WIDTH-1:0]     i_chip_idx,
    output logic [DATA_WIDTH-1:0]        o_decoded
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_CHIP = COUNTER_WIDTH'(NUM_PORTS - 1);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic        [DATA_WIDTH-1:0] r_decoded;
    logic signed [ACC_WIDTH-1:0] w_chip_ext;
    logic signed [ACC_WIDTH-1:0] w_term;
    logic signed [ACC_WIDTH-1:0] w_sum;

    assign w_chip_ext = ACC_WIDTH'(i_chip);
    assign w_term     = walsh_sign(PORT_IDX, 32'(i_chip_idx)) ? -w_chip_ext : w_chip_ext;
    assign w_sum      = r_acc + w_term;

    // NOTE: the accumulator must be reset, otherwise a mid-period reset would
    // leak partial sums into the first period afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_decoded <= '0;
        end else if (i_chip_idx == LAST_CHIP) begin
            // Divide by the code length: an arithmetic shift, then keep the data bits.
            r_decoded <= w_sum[COUNTER_WIDTH +: DATA_WIDTH];
            r_acc     <= '0;
        end else begin
            r_acc <= w_sum;
        end
    end

    assign o_decoded = r_decoded;

`ifdef ACDMA_ASSERT_EN
    a_exact_division: assert property (@(posedge clk) disable iff (rst)
        (i_chip_idx == LAST_CHIP) |-> (w_sum[COUNTER_WIDTH-1:0] == '0));
`else
`endif

endmodule

// File: rtl/acdma_crossbar_top.sv
// Aggregated-CDMA crossbar: Walsh-spreads all ports into one chip stream and
// despreads it per port. Define ACDMA_ASSERT_EN for simulation-only checks.
module acdma_crossbar_top
    import AggrCDMAPkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  data,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  decoded
);

    localparam logic [COUNTER_WIDTH-1:0] LAST_CHIP = COUNTER_WIDTH'(NUM_PORTS - 1);

    logic        [COUNTER_WIDTH-1:0] counter;
    logic        [COUNTER_WIDTH-1:0] decoder_counter;
    logic signed [CHIP_WIDTH-1:0]    r_chip_reg;
    logic signed [CHIP_WIDTH-1:0]    w_chip_sum;

    // NOTE: every variable written in always_comb gets a default first, so no
    // latch can be inferred.
    always_comb begin
        w_chip_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (walsh_sign(unsigned'(i), 32'(counter)))
                w_chip_sum = w_chip_sum - CHIP_WIDTH'(data[i]);
            else
                w_chip_sum = w_chip_sum + CHIP_WIDTH'(data[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, keeping decoder_counter exactly one cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter         <= '0;
            decoder_counter <= LAST_CHIP;
            r_chip_reg      <= '0;
        end else begin
            counter         <= (counter == LAST_CHIP) ? '0 : counter + COUNTER_WIDTH'(1);
            decoder_counter <= counter;
            r_chip_reg      <= w_chip_sum;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        acdma_despreader #(
            .PORT_IDX (g)
        ) u_despreader (
            .clk        (clk),
            .rst        (rst),
            .i_chip     (r_chip_reg),
            .i_chip_idx (decoder_counter),
            .o_decoded  (decoded[g])
        );
    end

`ifdef ACDMA_ASSERT_EN
    a_counter_lag: assert property (@(posedge clk) disable iff (rst)
        decoder_counter == counter - COUNTER_WIDTH'(1));
    a_pow2_ports: assert property (@(posedge clk)
        (NUM_PORTS & (NUM_PORTS - 1)) == 0);
`else
`endif

endmodule

// File: tb/tb_acdma_crossbar_top.sv
// Directed self-checking bench for acdma_crossbar_top (4 ports x 32 bits).
module tb_acdma_crossbar_top;

    localparam int N = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0][31:0]  data;
    logic [N-1:0][31:0]  decoded;
    logic [N-1:0][31:0]  exp_a;
    logic [N-1:0][31:0]  exp_b;

    int n_cmp = 0;
    int n_err = 0;

    acdma_crossbar_top dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .decoded (decoded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_counter(input logic [1:0] v);
        int k = 0;
        while (dut.counter != v && k < 16) begin
            step(1);
            k++;
        end
        check("wait_counter", 64'(dut.counter), 64'(v));
    endtask

    task automatic check_all(input string tag, input logic [N-1:0][31:0] exp);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_p%0d", tag, i), 64'(decoded[i]), 64'(exp[i]));
    endtask

    initial begin
        rst  = 1'b1;
        data = '0;
        step(3);
        check("rst_counter", 64'(dut.counter), 64'd0);
        check("rst_dec_counter", 64'(dut.decoder_counter), 64'd3);
        check_all("rst_decoded", '0);

        // Boundary values held from the first period after reset.
        exp_a = {32'h0, 32'h1, 32'h7FFFFFFF, 32'hFFFFFFFF};
        data  = exp_a;
        rst   = 1'b0;
        step(5);
        check("t1_dec_counter", 64'(dut.decoder_counter), 64'd0);
        check_all("t1_decoded", exp_a);

        // Random A then B, switching right after the wrap edge.
        for (int i = 0; i < N; i++) begin
            exp_a[i] = $urandom;
            exp_b[i] = $urandom;
        end
        data = exp_a;
        wait_counter(2'd0);
        step(4);
        check("ab_wrap_counter", 64'(dut.counter), 64'd0);
        data = exp_b;
        step(1);
        check("ab_dec_counter", 64'(dut.decoder_counter), 64'd0);
        check_all("ab_first", exp_a);
        step(4);
        check_all("ab_second", exp_b);

        // Maximum chip magnitude.
        data = {N{32'hFFFFFFFF}};
        wait_counter(2'd0);
        step(1);
        check("max_chip0", 64'(dut.r_chip_reg), 64'h3_FFFF_FFFC);
        step(4);
        check_all("max_decoded", {N{32'hFFFFFFFF}});

        // Reset in the middle of a period.
        exp_a = {32'hDEADBEEF, 32'h00000010, 32'h80000000, 32'h12345678};
        data  = exp_a;
        wait_counter(2'd2);
        rst = 1'b1;
        step(1);
        check_all("midrst_decoded", '0);
        check("midrst_counter", 64'(dut.counter), 64'd0);
        check("midrst_dec_counter", 64'(dut.decoder_counter), 64'd3);
        rst = 1'b0;
        step(5);
        check_all("postrst_decoded", exp_a);

        // Identical data on all ports: only chip 0 is non-zero.
        data = {N{32'h5A5A5A5A}};
        wait_counter(2'd0);
        step(1);
        check("same_chip0", 64'(dut.r_chip_reg), 64'h1_6969_6968);
        step(1);
        check("same_chip1", 64'(dut.r_chip_reg), 64'h0);
        step(1);
        check("same_chip2", 64'(dut.r_chip_reg), 64'h0);
        step(1);
        check("same_chip3", 64'(dut.r_chip_reg), 64'h0);
        step(1);
        check_all("same_decoded", {N{32'h5A5A5A5A}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
